avalon_io_ctrl: RTL and testbench
=================================

# avalon_io_ctrl

Parametrised Avalon-MM I/O controller that replaces the plain LED/input PIO pair on the Nios II system bus. It drives LED_W board LEDs with global PWM dimming and samples IN_W switch/button inputs through a synchroniser and debouncer. It also provides per-input rising-edge capture and a maskable interrupt to the CPU. It is instantiated inside the Qsys system; its conduit ports map to the board pins.

## Interface
- LED_W, 8, number of LED outputs (1..32)
- IN_W, 2, number of switch/button inputs (1..32)
- DEBOUNCE_CYC, 16, consecutive stable cycles required to accept an input change (≥1)
- PWM_W, 8, PWM counter/duty width (2..16)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- avs_address  in  3  word address of register
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, fixed read latency 1
- irq  out  1  interrupt request, level, active-high
- sw_in  in  IN_W  raw asynchronous switch/button inputs
- led_out  out  LED_W  LED drive, registered

## Operation
- Register map (word address):
  - 0 DATA_OUT: RW, LED_W bits.
  - 1 DATA_IN: RO, debounced inputs.
  - 2 EDGE_CAP: R, write-1-to-clear.
  - 3 IRQ_MASK: RW, IN_W bits.
  - 4 PWM_DUTY: RW, PWM_W bits.
  - 5..7: read 0, writes ignored. Unused upper bits read 0.
- Reset values:
  - DATA_OUT=0, IRQ_MASK=0, EDGE_CAP=0.
  - PWM_DUTY and active duty = all-ones.
  - Sync/debounced state = 0, debounce counters = 0, PWM counter = 0.
  - led_out=0, irq=0, avs_readdata=0.
- Input path, per channel:
  - Two-flop synchroniser, then debouncer.
  - Debounce counter increments while the synchronised value ≠ debounced value, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC-1 with a mismatch still present, the debounced value takes the synchronised value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYC cycles are never accepted.
- Edge capture:
  - A 0→1 transition of a debounced bit sets its EDGE_CAP bit on the same edge.
  - Writing 1 clears a bit; writing 0 has no effect.
  - If set and clear occur in the same cycle, set wins.
- irq = |(EDGE_CAP & IRQ_MASK), combinational from registers. Masking a pending bit deasserts irq without clearing EDGE_CAP.
- PWM:
  - PWM_W-bit free-running counter, wraps from all-ones to 0.
  - A write to PWM_DUTY updates a shadow register. The shadow is copied to active duty on the cycle the counter wraps to 0, so no partial periods occur.
  - pwm_on = (active duty == all-ones) or (counter < active duty). Duty 0 means always off.
  - led_out <= DATA_OUT & {LED_W{pwm_on}}.
- Bus:
  - Writes take effect on the clock edge where avs_write=1.
  - Reads return the register value as of the cycle avs_read was high, on avs_readdata the next cycle.
  - A simultaneous read and write to the same address returns the pre-write value.
  - avs_readdata is held at its last value when no read occurs.

## Timing
- sw_in stable from cycle 0 → synchronised value changes at cycle 2 → DATA_IN/EDGE_CAP/irq update at cycle 2+DEBOUNCE_CYC.
- DATA_OUT write at cycle n → led_out reflects it at cycle n+1 (subject to pwm_on).
- PWM_DUTY write → takes effect at the next counter wrap, 1..2^PWM_W cycles later. led_out follows one cycle after pwm_on.
- Read latency: exactly 1 cycle, with no waitrequest.
- Asynchronous reset assertion at any time, including mid-debounce or mid-PWM period, immediately forces every output and all state to its reset value. Pending edges are lost, and DATA_IN reads 0 until inputs re-debounce.

## Test plan
- Reset and idle:
  - Assert reset_n=0 mid-operation → led_out=0, irq=0, avs_readdata=0 immediately.
  - After release, read addr 4 → 0x000000FF (PWM_W=8).
- LED write:
  - Write 0xA5 to addr 0 at duty 0xFF → led_out=0xA5 one cycle later.
  - Read addr 0 → 0x000000A5.
- Debounce (DEBOUNCE_CYC=4):
  - sw_in[0] high for 3 cycles, then low → DATA_IN stays 0 and EDGE_CAP stays 0.
  - sw_in[0] held high → DATA_IN=1 at cycle 6 after the change.
- Edge capture and IRQ:
  - IRQ_MASK=0x1, sw_in[0] rising and debounced → EDGE_CAP=0x1 and irq=1.
  - Write 0x1 to addr 2 → irq=0 next cycle.
  - Clear coinciding with a new rising edge → bit remains 1.
- PWM:
  - DATA_OUT=0xFF, duty=0x40 → led_out high for 64 of every 256 cycles.
  - Duty 0 → led_out=0 continuously.
  - Duty written mid-period → old duty persists until the wrap.
- Unmapped address:
  - Write 0xFFFFFFFF to addr 6 → no register changes.
  - Read addr 6 → 0.

Source files
------------

// File: rtl/avalon_io_ctrl.sv
// ---------------------------------------------------------------------------
// avalon_io_ctrl
//   Avalon-MM I/O controller for the Nios II system bus. It drives LED_W
//   board LEDs with global PWM dimming. It samples IN_W switch/button inputs
//   through a two-flop synchroniser and a per-channel debouncer, and it
//   latches debounced rising edges into a write-1-to-clear register that
//   feeds a maskable level interrupt.
//
//   Register map (word address):
//     0 DATA_OUT  RW  LED_W bits
//     1 DATA_IN   RO  debounced inputs
//     2 EDGE_CAP  R/W1C
//     3 IRQ_MASK  RW  IN_W bits
//     4 PWM_DUTY  RW  PWM_W bits (shadow; active at the next counter wrap)
//     5..7        read 0, writes ignored
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   avs_address/read/write/writedata   Avalon-MM slave request
//   avs_readdata          read data, fixed latency 1, held between reads
//   irq                   level interrupt = |(EDGE_CAP & IRQ_MASK)
//   sw_in                 raw asynchronous switch/button inputs
//   led_out               registered LED drive
// ---------------------------------------------------------------------------
module avalon_io_ctrl #(
    parameter int LED_W        = 8,
    parameter int IN_W         = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int PWM_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [IN_W-1:0]  sw_in,
    output logic [LED_W-1:0] led_out
);

    // Counter only ever needs to hold 0..DEBOUNCE_CYC-1.
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [PWM_W-1:0] PWM_MAX  = '1;

    // State
    logic [LED_W-1:0]            r_data_out;
    logic [IN_W-1:0]             r_mask;
    logic [IN_W-1:0]             r_edge;
    logic [IN_W-1:0]             r_sync1;
    logic [IN_W-1:0]             r_sync2;
    logic [IN_W-1:0]             r_deb;
    logic [IN_W-1:0][CNT_W-1:0]  r_cnt;
    logic [PWM_W-1:0]            r_pwm_cnt;
    logic [PWM_W-1:0]            r_duty_sh;
    logic [PWM_W-1:0]            r_duty_act;
    logic [LED_W-1:0]            r_led;
    logic [31:0]                 r_readdata;

    // Next-state / decode
    logic [IN_W-1:0]             w_deb_nxt;
    logic [IN_W-1:0][CNT_W-1:0]  w_cnt_nxt;
    logic [IN_W-1:0]             w_rise;
    logic [IN_W-1:0]             w_edge_clr;
    logic                        w_wr_dout;
    logic                        w_wr_edge;
    logic                        w_wr_mask;
    logic                        w_wr_duty;
    logic                        w_wrap;
    logic                        w_pwm_on;
    logic [31:0]                 w_rdata;

    // Per-channel debouncer: count consecutive cycles of disagreement between
    // the synchronised and debounced value; accept on the DEBOUNCE_CYC-th.
    for (genvar g = 0; g < IN_W; g++) begin : g_deb
        logic w_mis;
        logic w_hit;
        assign w_mis        = r_sync2[g] ^ r_deb[g];
        assign w_hit        = w_mis && (r_cnt[g] == CNT_LAST);
        assign w_cnt_nxt[g] = (w_mis && !w_hit) ? r_cnt[g] + CNT_W'(1) : '0;
        assign w_deb_nxt[g] = w_hit ? r_sync2[g] : r_deb[g];
    end

    // Edge is flagged on the same clock edge the debounced bit rises.
    assign w_rise = w_deb_nxt & ~r_deb;

    assign w_wr_dout  = avs_write && (avs_address == 3'd0);
    assign w_wr_edge  = avs_write && (avs_address == 3'd2);
    assign w_wr_mask  = avs_write && (avs_address == 3'd3);
    assign w_wr_duty  = avs_write && (avs_address == 3'd4);
    assign w_edge_clr = w_wr_edge ? avs_writedata[IN_W-1:0] : '0;

    assign w_wrap   = (r_pwm_cnt == PWM_MAX);
    // All-ones duty is fully on; otherwise the last counter value would be dark.
    assign w_pwm_on = (r_duty_act == PWM_MAX) || (r_pwm_cnt < r_duty_act);

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            3'd0:    w_rdata[LED_W-1:0] = r_data_out;
            3'd1:    w_rdata[IN_W-1:0]  = r_deb;
            3'd2:    w_rdata[IN_W-1:0]  = r_edge;
            3'd3:    w_rdata[IN_W-1:0]  = r_mask;
            3'd4:    w_rdata[PWM_W-1:0] = r_duty_sh;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_mask     <= '0;
            r_edge     <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_deb      <= '0;
            r_cnt      <= '0;
            r_pwm_cnt  <= '0;
            r_duty_sh  <= PWM_MAX;
            r_duty_act <= PWM_MAX;
            r_led      <= '0;
            r_readdata <= '0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            r_deb   <= w_deb_nxt;
            r_cnt   <= w_cnt_nxt;

            // Set wins over a coincident W1C clear.
            r_edge <= (r_edge & ~w_edge_clr) | w_rise;

            if (w_wr_dout) r_data_out <= avs_writedata[LED_W-1:0];
            if (w_wr_mask) r_mask     <= avs_writedata[IN_W-1:0];
            if (w_wr_duty) r_duty_sh  <= avs_writedata[PWM_W-1:0];

            // Active duty changes only as the counter rolls to 0, so every
            // PWM period runs entirely at one duty. A duty write landing on
            // the wrap edge itself waits for the following wrap.
            if (w_wrap) r_duty_act <= r_duty_sh;
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);

            r_led <= r_data_out & {LED_W{w_pwm_on}};

            // Muxed from pre-write state, so read/write collisions return the old value.
            if (avs_read) r_readdata <= w_rdata;
        end
    end

    assign avs_readdata = r_readdata;
    assign led_out      = r_led;
    assign irq          = |(r_edge & r_mask);

endmodule

// File: tb/tb_avalon_io_ctrl.sv
module tb_avalon_io_ctrl;
    localparam int LED_W = 8;
    localparam int IN_W  = 2;
    localparam int DC    = 4;
    localparam int PWM_W = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       avs_address = '0;
    logic             avs_read = 1'b0;
    logic             avs_write = 1'b0;
    logic [31:0]      avs_writedata = '0;
    logic [31:0]      avs_readdata;
    logic             irq;
    logic [IN_W-1:0]  sw_in = '0;
    logic [LED_W-1:0] led_out;

    avalon_io_ctrl #(
        .LED_W(LED_W), .IN_W(IN_W), .DEBOUNCE_CYC(DC), .PWM_W(PWM_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .irq(irq), .sw_in(sw_in), .led_out(led_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Registers as seen by software, plus a sample history per input: an
    // input is accepted once the last DC synchronised samples all disagree
    // with the accepted value.
    logic [7:0]  m_dout, m_duty_sh, m_duty_act, m_cnt, m_led;
    logic [1:0]  m_mask, m_edge, m_deb, m_s1, m_s2, m_nd, m_clr;
    logic [31:0] m_hist [IN_W];
    int          m_nv;
    logic        m_irq, m_on;
    logic [31:0] rd_q [$];
    bit          rd_pend;

    function automatic logic [31:0] m_reg(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_dout};
            3'd1: return {30'd0, m_deb};
            3'd2: return {30'd0, m_edge};
            3'd3: return {30'd0, m_mask};
            3'd4: return {24'd0, m_duty_sh};
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit all_differ(input logic [31:0] h, input logic v);
        for (int k = 0; k < DC; k++) if (h[k] == v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_dout = 0; m_mask = 0; m_edge = 0; m_deb = 0; m_s1 = 0; m_s2 = 0;
            m_duty_sh = 8'hFF; m_duty_act = 8'hFF; m_cnt = 0; m_led = 0; m_irq = 0;
            m_nv = 0;
            for (int c = 0; c < IN_W; c++) m_hist[c] = 0;
            rd_q.delete();
            rd_pend = 0;
        end else begin
            if (avs_read) rd_q.push_back(m_reg(avs_address));
            rd_pend = avs_read;
            m_on  = (m_duty_act == 8'hFF) || (m_cnt < m_duty_act);
            m_led = m_on ? m_dout : 8'h00;
            m_nv  = (m_nv < 32) ? m_nv + 1 : 32;
            m_nd  = m_deb;
            for (int c = 0; c < IN_W; c++) begin
                m_hist[c] = {m_hist[c][30:0], m_s2[c]};
                if (m_nv >= DC && all_differ(m_hist[c], m_deb[c])) m_nd[c] = ~m_deb[c];
            end
            m_clr  = (avs_write && avs_address == 3'd2) ? avs_writedata[1:0] : 2'b00;
            m_edge = (m_edge & ~m_clr) | (m_nd & ~m_deb);
            m_deb  = m_nd;
            if (m_cnt == 8'hFF) m_duty_act = m_duty_sh;
            if (avs_write) begin
                case (avs_address)
                    3'd0: m_dout    = avs_writedata[7:0];
                    3'd3: m_mask    = avs_writedata[1:0];
                    3'd4: m_duty_sh = avs_writedata[7:0];
                    default: ;
                endcase
            end
            m_cnt = m_cnt + 8'd1;
            m_s2  = m_s1;
            m_s1  = sw_in;
            m_irq = |(m_edge & m_mask);
        end
    end

    // ---------------- monitor ----------------
    logic [31:0] last_rd;
    always @(negedge clk) begin
        if (!reset_n) begin
            last_rd = 0;
        end else begin
            chk("led_out", 32'(led_out), 32'(m_led));
            chk("irq", 32'(irq), 32'(m_irq));
            if (rd_pend) begin
                if (rd_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL readdata_sb: got 0x%0h expected a queued read", avs_readdata);
                end else begin
                    last_rd = rd_q.pop_front();
                    chk("readdata", avs_readdata, last_rd);
                end
            end else begin
                chk("readdata_hold", avs_readdata, last_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 3'd0, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        cyc(1, 0, a, 32'd0);
        cyc(0, 0, 3'd0, 32'd0);
        chk(name, avs_readdata, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        @(posedge clk); @(posedge clk); #2 reset_n = 1'b1;
    endtask

    int on_cnt;

    initial begin
        // reset and idle
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        idle(1);
        chk("idle_led", 32'(led_out), 32'h0);
        rd_chk("rst_duty", 3'd4, 32'h000000FF);

        // LED write at full duty
        cyc(0, 1, 3'd0, 32'hA5);
        idle(2);
        chk("led_a5", 32'(led_out), 32'hA5);
        rd_chk("rd_dout", 3'd0, 32'hA5);

        // glitch of 3 cycles must be rejected
        cyc(0, 1, 3'd3, 32'h1);
        cyc(0, 0, 3'd0, 32'd0); sw_in = 2'b01;
        idle(2);
        cyc(0, 0, 3'd0, 32'd0); sw_in = 2'b00;
        idle(8);
        chk("glitch_irq", 32'(irq), 32'h0);
        rd_chk("glitch_din", 3'd1, 32'h0);
        rd_chk("glitch_edge", 3'd2, 32'h0);

        // held input accepted on the 6th edge
        cyc(0, 0, 3'd0, 32'd0); sw_in = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            chk("deb_early", 32'(irq), 32'h0);
        end
        idle(1);
        chk("deb_accept", 32'(irq), 32'h1);
        rd_chk("din_1", 3'd1, 32'h1);
        rd_chk("edge_1", 3'd2, 32'h1);

        // W1C clears irq
        cyc(0, 1, 3'd2, 32'h1);
        idle(1);
        chk("w1c_irq", 32'(irq), 32'h0);

        // clear coinciding with a new rising edge: set wins
        cyc(0, 0, 3'd0, 32'd0); sw_in = 2'b00;
        idle(10);
        cyc(0, 0, 3'd0, 32'd0); sw_in = 2'b01;
        idle(4);
        cyc(0, 1, 3'd2, 32'h1);
        idle(1);
        chk("setwins_irq", 32'(irq), 32'h1);
        rd_chk("setwins_edge", 3'd2, 32'h1);
        cyc(0, 1, 3'd3, 32'h0);
        idle(1);
        chk("mask_irq", 32'(irq), 32'h0);
        rd_chk("mask_keeps_edge", 3'd2, 32'h1);
        cyc(0, 1, 3'd2, 32'h3);

        // PWM at 0x40: 64 of 256 cycles lit
        cyc(0, 1, 3'd0, 32'hFF);
        cyc(0, 1, 3'd4, 32'h40);
        idle(300);
        on_cnt = 0;
        repeat (256) begin idle(1); if (led_out == 8'hFF) on_cnt++; end
        chk("pwm_64", 32'(on_cnt), 32'd64);

        // duty 0: always dark
        cyc(0, 1, 3'd4, 32'h0);
        idle(300);
        on_cnt = 0;
        repeat (256) begin idle(1); if (led_out != 8'h00) on_cnt++; end
        chk("pwm_0", 32'(on_cnt), 32'd0);

        // duty written mid-period: model tracks the hand-over
        idle(100);
        cyc(0, 1, 3'd4, 32'h80);
        idle(300);

        // unmapped address
        cyc(0, 1, 3'd6, 32'hFFFFFFFF);
        rd_chk("unmapped", 3'd6, 32'h0);
        rd_chk("unm_dout", 3'd0, 32'hFF);
        rd_chk("unm_mask", 3'd3, 32'h0);
        rd_chk("unm_duty", 3'd4, 32'h80);

        // mid-operation reset with irq pending and LEDs lit
        cyc(0, 1, 3'd4, 32'hFF);
        cyc(0, 1, 3'd3, 32'h3);
        cyc(0, 0, 3'd0, 32'd0); sw_in = 2'b00;
        idle(10);
        cyc(0, 0, 3'd0, 32'd0); sw_in = 2'b10;
        idle(10);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        cyc(1, 0, 3'd0, 32'd0);
        idle(300);
        do_reset();
        rd_chk("post_rst_din", 3'd1, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [2:0] a;
            logic [31:0] d;
            r = $urandom_range(0, 9);
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (r < 3)       cyc(1, 0, a, 32'd0);
            else if (r < 5)  cyc(0, 1, a, d);
            else if (r == 9) cyc(1, 1, a, d);
            else             cyc(0, 0, 3'd0, 32'd0);
            if ($urandom_range(0, 5) == 0) sw_in[$urandom_range(0, IN_W-1)] ^= 1'b1;
            if (i == 1500) begin
                avs_read = 0; avs_write = 0;
                do_reset();
            end
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
